// File: rtl/timer.sv
// Kitchen-timer core: BCD keypad entry (shift-in) and a 1 s countdown over m:ss.
// Inputs are retimed through a two-stage pipeline; pgt is rising-edge detected after the pipeline.
module timer (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt,
  input  logic       enbn,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       done
);

  logic       pgt_s1, pgt_s2, pgt_prev;
  logic       loadn_s1, loadn_s2;
  logic       enbn_s1, enbn_s2;
  logic [3:0] d_s1, d_s2;

  logic       evt;
  logic [3:0] min_nxt, tens_nxt, ones_nxt;
  logic       done_nxt;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      pgt_s1   <= 1'b0;
      pgt_s2   <= 1'b0;
      pgt_prev <= 1'b0;
      loadn_s1 <= 1'b0;
      loadn_s2 <= 1'b0;
      enbn_s1  <= 1'b0;
      enbn_s2  <= 1'b0;
      d_s1     <= '0;
      d_s2     <= '0;
    end else begin
      pgt_s1   <= pgt;
      pgt_s2   <= pgt_s1;
      pgt_prev <= pgt_s2;
      loadn_s1 <= loadn;
      loadn_s2 <= loadn_s1;
      enbn_s1  <= enbn;
      enbn_s2  <= enbn_s1;
      d_s1     <= D;
      d_s2     <= d_s1;
    end
  end

  assign evt  = pgt_s2 & ~pgt_prev;
  assign zero = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);

  always_comb begin
    min_nxt  = min_ones;
    tens_nxt = sec_tens;
    ones_nxt = sec_ones;
    done_nxt = 1'b0;
    if (evt) begin
      if (enbn_s2) begin
        if (!zero) begin
          // Ripple borrow ones -> tens -> minutes; minutes is nonzero whenever it is reached.
          if (sec_ones != 4'd0) begin
            ones_nxt = sec_ones - 4'd1;
          end else begin
            ones_nxt = 4'd9;
            if (sec_tens != 4'd0) begin
              tens_nxt = sec_tens - 4'd1;
            end else begin
              tens_nxt = 4'd5;
              min_nxt  = min_ones - 4'd1;
            end
          end
          done_nxt = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
        end
      end else if (!loadn_s2 && (d_s2 <= 4'd9) && (sec_ones <= 4'd5)) begin
        // sec_ones moves into sec_tens, so it must already be a legal tens digit.
        min_nxt  = sec_tens;
        tens_nxt = sec_ones;
        ones_nxt = d_s2;
      end
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      done     <= 1'b0;
    end else begin
      min_ones <= min_nxt;
      sec_tens <= tens_nxt;
      sec_ones <= ones_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_timer.sv
// Directed bench for the timer: entry, entry limits, borrow chain, terminal count and resets.
module tb_timer;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic [3:0] D = '0;
  logic       loadn = 1'b1;
  logic       pgt = 1'b0;
  logic       enbn = 1'b0;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic       zero, done;

  int checks = 0;
  int errors = 0;

  logic [11:0] mid;
  int          dn;

  timer dut (
    .clk      (clk),
    .clearn   (clearn),
    .D        (D),
    .loadn    (loadn),
    .pgt      (pgt),
    .enbn     (enbn),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .zero     (zero),
    .done     (done)
  );

  always #5 clk = ~clk;

  wire [11:0] disp = {min_ones, sec_tens, sec_ones};

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pgt pulse held for 'hold' sampling edges; mid = display after edge k+1, dn = done-high samples.
  task automatic op(input logic [3:0] d, input logic en, input logic ld, input int hold,
                    output logic [11:0] m, output int n);
    @(negedge clk);
    D = d; enbn = en; loadn = ld; pgt = 1'b1;
    n = 0;
    m = '0;
    for (int i = 0; i < hold + 5; i++) begin
      @(negedge clk);
      if (i == hold - 1) pgt = 1'b0;
      if (i == 1) m = disp;
      if (done === 1'b1) n++;
    end
    loadn = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clearn = 1'b0;
    @(negedge clk);
    clearn = 1'b1;
  endtask

  initial begin
    // Reset / idle
    #2;
    chk("rst_disp", disp, 12'h000);
    chk("rst_zero", {11'd0, zero}, 12'd1);
    chk("rst_done", {11'd0, done}, 12'd0);
    @(negedge clk);
    clearn = 1'b1;
    op(4'd5, 1'b0, 1'b1, 1, mid, dn);
    chk("idle_no_load", disp, 12'h000);

    // Entry 1,3,0 -> 1:30 with update latency check
    op(4'd1, 1'b0, 1'b0, 1, mid, dn);
    chk("key1_not_yet", mid, 12'h000);
    chk("key1", disp, 12'h001);
    chk("key1_zero", {11'd0, zero}, 12'd0);
    op(4'd3, 1'b0, 1'b0, 1, mid, dn);
    chk("key3_not_yet", mid, 12'h001);
    chk("key3", disp, 12'h013);
    op(4'd0, 1'b0, 1'b0, 1, mid, dn);
    chk("key0", disp, 12'h130);
    op(4'hA, 1'b0, 1'b0, 1, mid, dn);
    chk("key_bad_digit", disp, 12'h130);

    // Entry limit: 0,7 then 5 rejected
    do_reset();
    chk("rst2", disp, 12'h000);
    op(4'd0, 1'b0, 1'b0, 1, mid, dn);
    op(4'd7, 1'b0, 1'b0, 1, mid, dn);
    chk("entry_007", disp, 12'h007);
    op(4'd5, 1'b0, 1'b0, 1, mid, dn);
    chk("entry_limit", disp, 12'h007);

    // Borrow chain 1:00 -> 0:59
    do_reset();
    op(4'd1, 1'b0, 1'b0, 1, mid, dn);
    op(4'd0, 1'b0, 1'b0, 1, mid, dn);
    op(4'd0, 1'b0, 1'b0, 1, mid, dn);
    chk("load_100", disp, 12'h100);
    op(4'd0, 1'b1, 1'b1, 1, mid, dn);
    chk("tick_059", disp, 12'h059);
    chk("tick_059_done", dn[11:0], 12'd0);

    // 0:10 -> 0:09
    do_reset();
    op(4'd1, 1'b0, 1'b0, 1, mid, dn);
    op(4'd0, 1'b0, 1'b0, 1, mid, dn);
    op(4'd0, 1'b1, 1'b1, 1, mid, dn);
    chk("tick_009", disp, 12'h009);

    // Long held tick gives one decrement; loadn low in run mode ignores D
    op(4'd0, 1'b1, 1'b1, 6, mid, dn);
    chk("held_tick", disp, 12'h008);
    op(4'd3, 1'b1, 1'b0, 1, mid, dn);
    chk("run_ignores_D", disp, 12'h007);

    // Terminal 0:01 -> 0:00 with one done pulse, then hold
    do_reset();
    op(4'd1, 1'b0, 1'b0, 1, mid, dn);
    op(4'd0, 1'b1, 1'b1, 1, mid, dn);
    chk("term_disp", disp, 12'h000);
    chk("term_zero", {11'd0, zero}, 12'd1);
    chk("term_done_once", dn[11:0], 12'd1);
    for (int t = 0; t < 3; t++) begin
      op(4'd0, 1'b1, 1'b1, 1, mid, dn);
      chk("term_hold", disp, 12'h000);
      chk("term_no_done", dn[11:0], 12'd0);
    end

    // Async reset mid-run at 0:45
    do_reset();
    op(4'd4, 1'b0, 1'b0, 1, mid, dn);
    op(4'd5, 1'b0, 1'b0, 1, mid, dn);
    chk("load_045", disp, 12'h045);
    op(4'd0, 1'b1, 1'b1, 1, mid, dn);
    chk("tick_044", disp, 12'h044);
    @(negedge clk);
    pgt = 1'b1;
    @(posedge clk);
    #3;
    pgt = 1'b0;
    clearn = 1'b0;
    #1;
    chk("async_rst_disp", disp, 12'h000);
    chk("async_rst_done", {11'd0, done}, 12'd0);
    #3;
    clearn = 1'b1;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("after_rst_disp", disp, 12'h000);
    chk("after_rst_done", dn[11:0], 12'd0);

    // pgt already high when reset releases -> exactly one event
    @(negedge clk);
    clearn = 1'b0;
    D = 4'd2; loadn = 1'b0; enbn = 1'b0; pgt = 1'b1;
    @(negedge clk);
    clearn = 1'b1;
    repeat (6) @(negedge clk);
    chk("pgt_high_at_release", disp, 12'h002);
    pgt = 1'b0;
    loadn = 1'b1;
    repeat (3) @(negedge clk);
    chk("pgt_high_single_evt", disp, 12'h002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 clearn  input  1  asynchronous active-low reset.
REQ-004 D  input  4  BCD digit from the keypad encoder; valid only while loadn=0.
REQ-005 loadn  input  1  active-low, low while a keypad key is held.
REQ-006 pgt  input  1  event strobe: debounced key strobe in entry mode, periodic 1 s tick in run mode; only its rising edge is significant.
REQ-007 enbn  input  1  mode select: 0 = entry (digit shift-in), 1 = run (countdown).
REQ-008 min_ones  output  4  minutes digit, BCD 0-9.
REQ-009 sec_tens  output  4  tens-of-seconds digit, BCD 0-5.
REQ-010 sec_ones  output  4  seconds digit, BCD 0-9.
REQ-011 zero  output  1  high when all three digits are 0.
REQ-012 done  output  1  one-clk pulse when a countdown reaches 0:00.

Function
REQ-013 pgt, D, loadn and enbn SHALL pass through a 2-stage register pipeline (stage s1, stage s2) so that all four stay aligned.
REQ-014 A third flop SHALL hold the previous s2 value of pgt.
REQ-015 An event SHALL be detected when s2.pgt=1 and the previous-value flop=0.
REQ-016 If pgt is first sampled high at edge k, the digit registers and done SHALL update at edge k+2.
REQ-017 A pgt high level SHALL produce exactly one event, however long it is held.
REQ-018 A pgt high pulse captured by a single clk edge SHALL be sufficient to produce an event.
REQ-019 No digit register SHALL change except on an event or on reset.
REQ-020 Entry shift: on an event with enbn=0, loadn=0 and the shift accepted, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
REQ-021 The shift SHALL be rejected, leaving all digits unchanged, if D>9.
REQ-022 The shift SHALL also be rejected if the current sec_ones>5, because it would become sec_tens.
REQ-023 On an event with enbn=0 and loadn=1, there SHALL be no action.
REQ-024 Run decrement: on an event with enbn=1 and zero=0, the count SHALL decrease by exactly one second.
REQ-025 During a decrement, sec_ones SHALL decrement; if sec_ones was 0 it SHALL become 9 and borrow from sec_tens.
REQ-026 On a borrow, sec_tens SHALL decrement; if sec_tens was 0 it SHALL become 5 and borrow from min_ones.
REQ-027 On a borrow, min_ones SHALL decrement; when a borrow occurs it is guaranteed nonzero because zero=0.
REQ-028 On an event with enbn=1 and zero=1, the digits SHALL hold, with no wrap to 9:59 and no done pulse.
REQ-029 When enbn=1 and loadn=0 coincide, the block SHALL decrement and SHALL ignore D.
REQ-030 zero SHALL be decoded combinationally from the digit registers.
REQ-031 done SHALL be registered: high for exactly the one cycle following the decrement that produces 0:00, otherwise 0.
REQ-032 A change of enbn between events SHALL take effect on the next event via the pipeline, with no other side effect.
REQ-033 The reachable digit range SHALL be 0:00 to 9:59, and all digits SHALL always hold legal BCD.

Reset
REQ-034 clearn=0 SHALL asynchronously force min_ones=0, sec_tens=0, sec_ones=0, done=0 and zero=1.
REQ-035 clearn=0 SHALL also clear all pipeline and previous-value flops to 0.
REQ-036 Reset asserted mid-countdown or mid-entry SHALL discard the count; no done SHALL be generated.
REQ-037 After clearn rises, a pgt already high SHALL produce one event once it propagates through the pipeline.

Verification
REQ-038 Reset/idle: assert clearn=0, then release -> digits 0:00, zero=1, done=0; pgt pulses with loadn=1 change nothing.
REQ-039 Entry: enbn=0, keys 1,3,0 (loadn=0 plus one pgt pulse each) -> 1:30, each update exactly 2 edges after pgt is first sampled high; D=4'hA -> no change.
REQ-040 Entry limit: keys 0,7,5 -> after 0,7 the display is 0:07; key 5 is rejected and the display stays 0:07.
REQ-041 Borrow chain: load 1:00, enbn=1, one tick -> 0:59; from 0:10, one tick -> 0:09.
REQ-042 Terminal: from 0:01, one tick -> 0:00, zero=1, done high exactly one clk; three further ticks -> no change, done stays 0.
REQ-043 Reset mid-run: at 0:45 with ticks running, pulse clearn=0 asynchronously (not clk-aligned) -> 0:00 immediately, done=0.
